twiddle_sequencer: RTL

- Sequences the twiddle-factor block ROM for a radix-2 decimation-in-time FFT of N = 2**LOG2N points.
- Generates the per-butterfly ROM address for every stage and drives the ROM enable. The ROM has a 1-cycle registered read and holds its output while the enable is low.
- Presents the fetched twiddle to the butterfly datapath on a valid/ready stream, with full-throughput backpressure.
- Sits between the FFT top-level control (start/done) and the butterfly unit.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/twiddle_addr_gen.sv | 41 ++++
 rtl/twiddle_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer state encoding, stage-index width and
// the twiddle-address rule used by both the twiddle and data address paths.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bits needed to hold a stage index 0..log2n-1 (at least one bit).
  function automatic int stage_w(input int log2n);
    return (log2n < 2) ? 1 : $clog2(log2n);
  endfunction

  // Twiddle ROM address for butterfly b of stage s:
  // keep the low s bits of b and left-align them into a log2n-bit address.
  // The caller truncates the result to log2n bits.
  function automatic logic [31:0] addr(input logic [31:0] s,
                                       input logic [31:0] b,
                                       input int          log2n);
    logic [31:0] mask;
    mask = (32'd1 << s) - 32'd1;
    return (b & mask) << (log2n - 1 - int'(s));
  endfunction

endpackage

// File: rtl/twiddle_addr_gen.sv
// Stage/butterfly counters for the radix-2 DIT twiddle walk, plus the
// combinational ROM address derived from them.
module twiddle_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       advance,
  output logic [stage_w(LOG2N)-1:0]  stage,
  output logic [LOG2N-1:0]           rom_addr,
  output logic                       last
);

  localparam int SW = stage_w(LOG2N);
  localparam int BW = LOG2N - 1;

  logic [BW-1:0] bfly;

  // Final butterfly of the final stage: the counters stop here.
  assign last = (stage == SW'(LOG2N - 1)) && (bfly == '1);

  // Address follows the counters with no register in between.
  assign rom_addr = LOG2N'(addr(32'(stage), 32'(bfly), LOG2N));

  // Butterfly index is inner-most; wrapping it steps the stage.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      stage <= '0;
      bfly  <= '0;
    end else if (advance && !last) begin
      bfly <= bfly + BW'(1);
      if (bfly == '1) begin
        stage <= stage + SW'(1);
      end
    end
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Twiddle ROM sequencer: walks every stage/butterfly of an N-point radix-2
// DIT FFT, reads the twiddle ROM and streams the words out on valid/ready.
// The ROM's own output register doubles as the stream data register, so a
// stall simply withholds rom_en and the word stays put.
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N      = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rom_en,
  output logic [LOG2N-1:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_dout,
  output logic                       tw_valid,
  input  logic                       tw_ready,
  output logic [DATA_WIDTH-1:0]      tw_data,
  output logic [stage_w(LOG2N)-1:0]  tw_stage,
  output logic                       tw_last
);

  localparam int SW = stage_w(LOG2N);

  state_t        state;
  state_t        state_nxt;
  logic          issue;
  logic          clear;
  logic          hs;
  logic          done_nxt;
  logic          last;
  logic [SW-1:0] stage;

  twiddle_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .advance  (issue),
    .stage    (stage),
    .rom_addr (rom_addr),
    .last     (last)
  );

  assign busy    = (state != IDLE);
  assign rom_en  = issue;
  assign tw_data = rom_dout;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, ROM issue and completion detect.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    clear     = 1'b0;
    done_nxt  = 1'b0;
    hs        = tw_valid && tw_ready;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
        // Read only when the output slot is empty or being emptied.
        issue = !tw_valid || tw_ready;
        if (issue && last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && tw_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stream sideband registers, loaded alongside the ROM read so they line
  // up with the word that appears one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      tw_valid <= 1'b0;
      tw_stage <= '0;
      tw_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      tw_valid <= issue || (tw_valid && !tw_ready);
      done     <= done_nxt;
      if (issue) begin
        tw_stage <= stage;
        tw_last  <= last;
      end
    end
  end

endmodule
